// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : Bundle of the SPI pins and the decoded-frame outputs of
//                spi_slave.
//                master modport : drives cs/sck/mosi, observes the rest
//                slave  modport : the spi_slave side
//  Signals     : cs         - chip select, active-low
//                sck        - serial clock, SPI mode 0
//                mosi       - serial data to the slave, MSB first
//                miso       - serial data from the slave, MSB first
//                rx_command - command byte of the last complete frame
//                rx_address - address of the last complete frame
//                rx_data    - data word of the last complete frame
//                rx_valid   - one-clk pulse marking a completed frame
//                busy       - high while a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_if;
    logic        cs;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic [7:0]  rx_command;
    logic [23:0] rx_address;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;

    modport master (
        output cs, sck, mosi,
        input  miso, rx_command, rx_address, rx_data, rx_valid, busy
    );

    modport slave (
        input  cs, sck, mosi,
        output miso, rx_command, rx_address, rx_data, rx_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI mode-0 slave. A frame is 64 sck rising edges while cs is
//                low: 8-bit command, 24-bit address, 32-bit data, MSB first.
//                Completed frames are presented on rx_* with a one-clk
//                rx_valid pulse. Raising cs early aborts the frame.
//                Optional register file (macro SPI_SLAVE_REGFILE_EN):
//                  cmd 8'h02 writes rx_data to regfile[address low bits]
//                  cmd 8'h03 returns regfile[address] on miso during the
//                  data phase.
//                Without the macro miso is tied to 0.
//  Parameters  : ADDR_BITS - low address bits indexing 2**ADDR_BITS words
//  Ports       : clk - system clock, rising edge
//                rst - asynchronous reset, active-low
//                bus - spi_slave_if.slave (cs, sck, mosi, miso, rx_command,
//                      rx_address, rx_data, rx_valid, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int ADDR_BITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_CMD  = 3'd1;
    localparam logic [2:0] c_ST_ADDR = 3'd2;
    localparam logic [2:0] c_ST_DATA = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    // ---------------- input synchronisers / edge detect ----------------
    logic [1:0] r_cs_sync;
    logic [1:0] r_sck_sync;
    logic [1:0] r_mosi_sync;
    logic       r_cs_d;
    logic       r_sck_d;

    // cs synchroniser resets to "low" so that a cs already held low when
    // reset is released does not look like a fresh falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_sync   <= 2'b00;
            r_sck_sync  <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_d      <= 1'b0;
            r_sck_d     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], bus.cs};
            r_sck_sync  <= {r_sck_sync[0], bus.sck};
            r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
            r_cs_d      <= r_cs_sync[1];
            r_sck_d     <= r_sck_sync[1];
        end
    end

    logic w_cs;
    logic w_cs_fall;
    logic w_sck_rise;
    assign w_cs       = r_cs_sync[1];
    assign w_cs_fall  = r_cs_d & ~w_cs;
    assign w_sck_rise = r_sck_sync[1] & ~r_sck_d;

    // ---------------- FSM ----------------
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [5:0]  r_bit_cnt;
    logic [62:0] r_shift;
    logic        w_shift_en;
    logic        w_frame_done;
    logic [63:0] w_frame;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // cs high takes priority over any sck edge in the active states.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_cs_fall) w_state_nxt = c_ST_CMD;
            c_ST_CMD: begin
                if (w_cs)                                 w_state_nxt = c_ST_IDLE;
                else if (w_sck_rise && r_bit_cnt == 6'd7)  w_state_nxt = c_ST_ADDR;
            end
            c_ST_ADDR: begin
                if (w_cs)                                 w_state_nxt = c_ST_IDLE;
                else if (w_sck_rise && r_bit_cnt == 6'd31) w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_cs)                                 w_state_nxt = c_ST_IDLE;
                else if (w_sck_rise && r_bit_cnt == 6'd63) w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: if (w_cs) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_shift_en   = ((r_state == c_ST_CMD) || (r_state == c_ST_ADDR) ||
                           (r_state == c_ST_DATA)) && !w_cs && w_sck_rise;
    assign w_frame_done = (r_state == c_ST_DATA) && w_shift_en && (r_bit_cnt == 6'd63);
    assign w_frame      = {r_shift, r_mosi_sync[1]};

    // ---------------- frame capture ----------------
    logic [7:0]  r_rx_command;
    logic [23:0] r_rx_address;
    logic [31:0] r_rx_data;
    logic        r_rx_valid;

    // The counter wraps to 0 on the 64th bit; DONE does not use it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt    <= 6'd0;
            r_shift      <= '0;
            r_rx_command <= 8'd0;
            r_rx_address <= 24'd0;
            r_rx_data    <= 32'd0;
            r_rx_valid   <= 1'b0;
        end else begin
            r_rx_valid <= w_frame_done;
            if (r_state == c_ST_IDLE) begin
                r_bit_cnt <= 6'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
                r_shift   <= w_frame[62:0];
            end
            if (w_frame_done) begin
                r_rx_command <= w_frame[63:56];
                r_rx_address <= w_frame[55:32];
                r_rx_data    <= w_frame[31:0];
            end
        end
    end

    assign bus.rx_command = r_rx_command;
    assign bus.rx_address = r_rx_address;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.busy       = (r_state != c_ST_IDLE);

`ifdef SPI_SLAVE_REGFILE_EN
    // ---------------- register file and read-back path ----------------
    localparam int c_DEPTH = 2 ** ADDR_BITS;

    logic [31:0] r_regfile [c_DEPTH];
    logic [31:0] r_miso_sr;
    logic        w_sck_fall;

    assign w_sck_fall = ~r_sck_sync[1] & r_sck_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_DEPTH; i++) r_regfile[i] <= 32'd0;
        end else if (w_frame_done && (w_frame[63:56] == 8'h02)) begin
            r_regfile[w_frame[32 +: ADDR_BITS]] <= w_frame[31:0];
        end
    end

    // On the first sck fall of the data phase the shift register holds
    // exactly {command, address}; a non-read command loads zeros so miso
    // stays low for the rest of the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_miso_sr <= 32'd0;
        end else if (r_state == c_ST_IDLE) begin
            r_miso_sr <= 32'd0;
        end else if ((r_state == c_ST_DATA) && !w_cs && w_sck_fall) begin
            if (r_bit_cnt == 6'd32)
                r_miso_sr <= (r_shift[31:24] == 8'h03) ? r_regfile[r_shift[ADDR_BITS-1:0]] : 32'd0;
            else
                r_miso_sr <= {r_miso_sr[30:0], 1'b0};
        end
    end

    assign bus.miso = r_miso_sr[31];
`else
    // No register file: the index width is only kept so the parameter keeps
    // its meaning for instantiating code.
    logic [ADDR_BITS-1:0] w_unused_index;
    assign w_unused_index = r_rx_address[ADDR_BITS-1:0];
    assign bus.miso       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Directed self-checking bench for spi_slave. Drives complete,
//                aborted, reset-interrupted and over-length SPI frames and
//                compares rx_* / miso / busy against hand-computed values.
//                Read-back expectations follow SPI_SLAVE_REGFILE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int HALF = 8;   // sck half period in clk cycles

`ifdef SPI_SLAVE_REGFILE_EN
    localparam bit c_REGFILE = 1'b1;
`else
    localparam bit c_REGFILE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_valid;

    spi_slave_if bus ();

    spi_slave #(
        .ADDR_BITS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.rx_valid === 1'b1) n_valid++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame of nbits sck periods. If rst_bit >= 0, reset is pulsed
    // just before that bit and the all-zero output state is checked.
    task automatic spi_frame(input logic [7:0] cmd, input logic [23:0] addr,
                             input logic [31:0] data, input int nbits,
                             input int rst_bit,
                             output logic [31:0] miso_tail, output logic miso_head);
        logic [63:0] f;
        f         = {cmd, addr, data};
        miso_tail = 32'd0;
        miso_head = 1'b0;
        n_valid   = 0;
        @(negedge clk);
        bus.sck = 1'b0;
        bus.cs  = 1'b0;
        wait_clk(6);
        check("busy_start", bus.busy, 1);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst = 1'b0;
                #1;
                check("rst_busy", bus.busy, 0);
                check("rst_outputs", {bus.rx_valid, bus.miso, bus.rx_command},
                      {1'b0, 1'b0, 8'h00});
                check("rst_addr_data", {bus.rx_address, bus.rx_data}, 64'd0);
                wait_clk(2);
                rst = 1'b1;
            end
            bus.mosi = (i < 64) ? f[63-i] : 1'b0;
            wait_clk(HALF);
            if (i >= 32 && i < 64) miso_tail = {miso_tail[30:0], bus.miso};
            else if (i < 32)       miso_head = miso_head | bus.miso;
            bus.sck = 1'b1;
            wait_clk(HALF);
            bus.sck = 1'b0;
        end
        wait_clk(HALF);
        bus.cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("busy_release", bus.busy, 0);
        wait_clk(6);
    endtask

    logic [31:0] tail;
    logic        head;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        n_valid  = 0;
        rst      = 1'b0;
        bus.cs   = 1'b1;
        bus.sck  = 1'b0;
        bus.mosi = 1'b0;
        wait_clk(3);
        check("reset_busy", bus.busy, 0);
        check("reset_valid_miso", {bus.rx_valid, bus.miso}, 2'b00);
        check("reset_cmd", bus.rx_command, 8'h00);
        check("reset_addr", bus.rx_address, 24'h0);
        check("reset_data", bus.rx_data, 32'h0);
        rst = 1'b1;
        wait_clk(5);

        // write 0x789ABCDE to word 5
        spi_frame(8'h02, 24'h000005, 32'h789ABCDE, 64, -1, tail, head);
        check("wr_valid_cnt", n_valid, 1);
        check("wr_cmd", bus.rx_command, 8'h02);
        check("wr_addr", bus.rx_address, 24'h000005);
        check("wr_data", bus.rx_data, 32'h789ABCDE);
        check("wr_miso", {head, tail}, 33'd0);

        // read word 5 back
        spi_frame(8'h03, 24'h000005, 32'h00000000, 64, -1, tail, head);
        check("rd5_valid_cnt", n_valid, 1);
        check("rd5_cmd", bus.rx_command, 8'h03);
        check("rd5_head", head, 0);
        check("rd5_miso", tail, c_REGFILE ? 32'h789ABCDE : 32'h0);

        // unknown command
        spi_frame(8'hA5, 24'h123456, 32'h789ABCDE, 64, -1, tail, head);
        check("unk_valid_cnt", n_valid, 1);
        check("unk_cmd", bus.rx_command, 8'hA5);
        check("unk_addr", bus.rx_address, 24'h123456);
        check("unk_data", bus.rx_data, 32'h789ABCDE);
        check("unk_miso", {head, tail}, 33'd0);

        // word 6 (index of 0x123456) must still be zero
        spi_frame(8'h03, 24'h000006, 32'h00000000, 64, -1, tail, head);
        check("rd6_miso", tail, 32'h0);
        check("rd6_addr", bus.rx_address, 24'h000006);

        // abort after 20 bits
        spi_frame(8'h02, 24'h000007, 32'h11111111, 20, -1, tail, head);
        check("abort_valid_cnt", n_valid, 0);
        check("abort_cmd", bus.rx_command, 8'h03);
        check("abort_addr", bus.rx_address, 24'h000006);
        check("abort_data", bus.rx_data, 32'h0);
        spi_frame(8'h03, 24'h000007, 32'h00000000, 64, -1, tail, head);
        check("rd7_miso", tail, 32'h0);

        // upper address bits ignored: 0x15 and 0x25 both index word 5
        spi_frame(8'h02, 24'h000015, 32'hCAFEF00D, 64, -1, tail, head);
        check("wr15_addr", bus.rx_address, 24'h000015);
        spi_frame(8'h03, 24'h000025, 32'h00000000, 64, -1, tail, head);
        check("rd25_miso", tail, c_REGFILE ? 32'hCAFEF00D : 32'h0);

        // reset during the address phase
        spi_frame(8'h02, 24'h000003, 32'hDEADBEEF, 64, 16, tail, head);
        check("rstf_valid_cnt", n_valid, 0);
        check("rstf_cmd_data", {bus.rx_command, bus.rx_data}, 40'd0);

        // first frame after reset decodes normally; register file is cleared
        spi_frame(8'h03, 24'h000015, 32'h13579BDF, 64, -1, tail, head);
        check("post_rst_valid_cnt", n_valid, 1);
        check("post_rst_cmd", bus.rx_command, 8'h03);
        check("post_rst_addr", bus.rx_address, 24'h000015);
        check("post_rst_data", bus.rx_data, 32'h13579BDF);
        check("post_rst_miso", tail, 32'h0);

        // over-length frame: 70 sck edges
        spi_frame(8'h5A, 24'hABCDEF, 32'h01234567, 70, -1, tail, head);
        check("long_valid_cnt", n_valid, 1);
        check("long_cmd", bus.rx_command, 8'h5A);
        check("long_addr", bus.rx_address, 24'hABCDEF);
        check("long_data", bus.rx_data, 32'h01234567);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
